alu_multibyte_seq: RTL and testbench
====================================

Name: alu_multibyte_seq

Overview:
- Sequencer that runs multi-byte (default 16-bit) ADD/SUB/CMP/SHL/AND/OR on the existing 8-bit binary ALU, one byte per cycle, least-significant byte first.
- Sits in the EX stage between the decode/EX pipeline register and the 8-bit ALU.
- Drives the ALU enable, operands and 14-bit control vector, and samples the ALU result and carry each cycle.
- Stalls the pipeline while the operation runs.

Parameters:
- NUM_BYTES, 2, operand width in bytes; legal range 2..4. Operand width W = 8*NUM_BYTES.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE.
- op  in  3  000 ADD, 001 SUB, 010 CMP, 011 SHL, 100 AND, 101 OR, 110/111 illegal.
- a  in  W  operand A.
- b  in  W  operand B.
- alu_en  out  1  ALU enable.
- alu_op1  out  8  ALU operand 1.
- alu_op2  out  8  ALU operand 2.
- alu_ctrl  out  [0:13]  ALU control. Bit indices: 0 add, 3 and_bitwise, 4 or_bitwise, 7 carry_in, 8 complement, 10 compare, 12 lgcl_en; all other bits are 0.
- alu_dout  in  8  ALU result.
- alu_cout  in  1  ALU carry out.
- busy  out  1  operation in progress.
- stall  out  1  pipeline hold; equals busy OR start-accepted-this-cycle.
- done  out  1  one-cycle completion pulse.
- result  out  W  registered result.
- cout  out  1  final carry.
- cmp_gt, cmp_lt, cmp_eq  out  1 each  unsigned compare flags.
- illegal_op  out  1  set with done when op is illegal.

Behaviour:
- Reset (async, rst_n=0): state IDLE. All outputs 0, including alu_ctrl, result and flags. Internal byte counter 0.
- FSM states: IDLE, RUN, DONE.
- IDLE → RUN on a start rising-edge sample.
  - a, b and op are latched at that edge; later changes to the inputs are ignored.
  - Byte counter k is cleared and the carry register is cleared.
  - If op is illegal, the FSM goes IDLE → DONE directly: illegal_op=1, result, cout and flags unchanged.
- RUN, byte k:
  - alu_en=1, alu_op1=A[8k+7:8k].
  - alu_op2=B byte k, except for SHL, where alu_op2=A byte k (shift left implemented as A+A).
  - ADD/SHL: add=1; carry_in = 0 for k=0, else the registered carry.
  - SUB/CMP: add=1, complement=1; carry_in = 1 for k=0, else the registered carry. CMP also sets compare=1.
  - AND: lgcl_en=1, and_bitwise=1. OR: lgcl_en=1, or_bitwise=1. Carry is not used.
  - At the clock edge, alu_dout is captured into the byte-k slot of the internal result and alu_cout into the carry register. Then k increments.
  - When k=NUM_BYTES-1 is captured, the FSM goes RUN → DONE.
- DONE (one cycle):
  - done=1; alu_en=0; alu_ctrl=0.
  - ADD/SUB/SHL/AND/OR: result is updated. cout = final carry for ADD/SUB/SHL, 0 for AND/OR.
  - CMP: result and cout are unchanged. cmp_eq = (internal W-bit difference == 0). cmp_gt = carry & !eq. cmp_lt = !carry.
  - Compare flags hold until the next CMP completes.
  - DONE → IDLE unconditionally. In DONE, illegal_op is 0 unless op was illegal.
- Latency: done asserts NUM_BYTES+1 cycles after the edge that accepted start. The next start may be accepted in the cycle after done (back-to-back throughput NUM_BYTES+2).
- busy=1 in RUN and DONE. start while busy is ignored (not queued).
- Outside RUN, alu_en=0 and alu_ctrl=0, which keeps the ALU quiescent for the RNS path.
- Wrap-around: ADD overflow drops bit W into cout. SUB borrow: cout=0 means a<b.
- Reset mid-operation: immediate return to IDLE with all outputs 0; the partial result is discarded and no done is issued.

Test Plan:
- ADD, NUM_BYTES=2, a=0x00FF, b=0x0001:
  - k=0 drives carry_in=0; k=1 drives carry_in=1.
  - result=0x0100, cout=0; done exactly 3 cycles after start accepted.
- SUB, a=0x1234, b=0x1234 → result=0x0000, cout=1. SUB, a=0x0001, b=0x0002 → result=0xFFFF, cout=0.
- CMP with result preloaded to 0xBEEF:
  - a=0x0100, b=0x00FF → cmp_gt=1, lt=0, eq=0.
  - a=0x0001, b=0x0002 → cmp_lt=1.
  - a=b=0x5A5A → cmp_eq=1.
  - result stays 0xBEEF throughout.
- SHL, a=0x8001 → result=0x0002, cout=1. AND 0xF0F0 & 0x0FF0 → 0x00F0, cout=0. OR → 0xFFF0.
- Robustness:
  - start pulsed during RUN is ignored.
  - op=111 → done after 1 cycle with illegal_op=1 and result unchanged.
  - rst_n low during the k=1 cycle → outputs 0 asynchronously, no done.
  - A fresh ADD after reset completes correctly.
- NUM_BYTES=4, ADD 0x00FFFFFF + 1 → 0x01000000, done 5 cycles after start.

Source files
------------

// File: rtl/alu_multibyte_seq.sv
// alu_multibyte_seq: runs W-bit ADD/SUB/CMP/SHL/AND/OR on the shared 8-bit ALU,
// one byte per cycle, LSB first. The EX pipeline is held via stall while busy.
module alu_multibyte_seq #(
  parameter int NUM_BYTES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [2:0]             op,
  input  logic [8*NUM_BYTES-1:0] a,
  input  logic [8*NUM_BYTES-1:0] b,
  output logic                   alu_en,
  output logic [7:0]             alu_op1,
  output logic [7:0]             alu_op2,
  output logic [0:13]            alu_ctrl,
  input  logic [7:0]             alu_dout,
  input  logic                   alu_cout,
  output logic                   busy,
  output logic                   stall,
  output logic                   done,
  output logic [8*NUM_BYTES-1:0] result,
  output logic                   cout,
  output logic                   cmp_gt,
  output logic                   cmp_lt,
  output logic                   cmp_eq,
  output logic                   illegal_op
);

  localparam int KW = $clog2(NUM_BYTES);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_CMP = 3'b010;
  localparam logic [2:0] OP_SHL = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // ALU control vector bit positions
  localparam int C_ADD  = 0;
  localparam int C_AND  = 3;
  localparam int C_OR   = 4;
  localparam int C_CIN  = 7;
  localparam int C_CMPL = 8;
  localparam int C_CMP  = 10;
  localparam int C_LGCL = 12;

  logic [1:0]                  state;
  logic [KW-1:0]               k;
  logic                        carry_q;
  logic [2:0]                  op_q;
  logic [NUM_BYTES-1:0][7:0]   a_q, b_q, res_q, res_nxt;
  logic                        last_byte;
  logic                        diff_zero;

  assign last_byte  = (k == KW'(NUM_BYTES - 1));
  assign busy       = (state != S_IDLE);
  assign stall      = busy | (state == S_IDLE && start);
  assign done       = (state == S_DONE);
  assign illegal_op = done & (op_q >= 3'd6);
  assign diff_zero  = (res_nxt == '0);

  // Partial result with the byte currently leaving the ALU merged in
  always_comb begin
    res_nxt    = res_q;
    res_nxt[k] = alu_dout;
  end

  // ALU drive: active only in RUN so the ALU stays quiescent otherwise
  always_comb begin
    alu_en   = 1'b0;
    alu_op1  = 8'h00;
    alu_op2  = 8'h00;
    alu_ctrl = '0;
    if (state == S_RUN) begin
      alu_en  = 1'b1;
      alu_op1 = a_q[k];
      // shift-left is A+A, so both ALU operands come from A
      alu_op2 = (op_q == OP_SHL) ? a_q[k] : b_q[k];
      case (op_q)
        OP_ADD, OP_SHL: begin
          alu_ctrl[C_ADD] = 1'b1;
          alu_ctrl[C_CIN] = (k != '0) & carry_q;
        end
        OP_SUB, OP_CMP: begin
          alu_ctrl[C_ADD]  = 1'b1;
          alu_ctrl[C_CMPL] = 1'b1;
          alu_ctrl[C_CIN]  = (k == '0) | carry_q;
          alu_ctrl[C_CMP]  = (op_q == OP_CMP);
        end
        OP_AND: begin
          alu_ctrl[C_LGCL] = 1'b1;
          alu_ctrl[C_AND]  = 1'b1;
        end
        OP_OR: begin
          alu_ctrl[C_LGCL] = 1'b1;
          alu_ctrl[C_OR]   = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Sequencer FSM; final outputs are written on the last byte edge so they
  // are already valid while done is high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      k       <= '0;
      carry_q <= 1'b0;
      op_q    <= 3'b000;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      result  <= '0;
      cout    <= 1'b0;
      cmp_gt  <= 1'b0;
      cmp_lt  <= 1'b0;
      cmp_eq  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            op_q    <= op;
            k       <= '0;
            carry_q <= 1'b0;
            state   <= (op >= 3'd6) ? S_DONE : S_RUN;
          end
        end
        S_RUN: begin
          res_q   <= res_nxt;
          carry_q <= alu_cout;
          k       <= k + 1'b1;
          if (last_byte) begin
            state <= S_DONE;
            case (op_q)
              OP_ADD, OP_SUB, OP_SHL: begin
                result <= res_nxt;
                cout   <= alu_cout;
              end
              OP_AND, OP_OR: begin
                result <= res_nxt;
                cout   <= 1'b0;
              end
              OP_CMP: begin
                cmp_eq <= diff_zero;
                cmp_gt <= alu_cout & ~diff_zero;
                cmp_lt <= ~alu_cout;
              end
              default: ;
            endcase
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_multibyte_seq.sv
// Directed bench for alu_multibyte_seq: a 2-byte and a 4-byte instance, each
// wired to a behavioural 8-bit ALU model.
module tb_alu_multibyte_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        start2, start4;
  logic [2:0]  op;
  logic [15:0] a2, b2;
  logic [31:0] a4, b4;

  logic        en2, en4, busy2, busy4, stall2, stall4, done2, done4;
  logic [7:0]  op1_2, op2_2, op1_4, op2_4, dout2, dout4;
  logic [0:13] ctrl2, ctrl4;
  logic        acout2, acout4, cout2, cout4;
  logic [15:0] result2;
  logic [31:0] result4;
  logic        gt2, lt2, eq2, gt4, lt4, eq4, ill2, ill4;

  logic        ci [0:15];

  // External 8-bit ALU behaviour
  function automatic logic [8:0] alu_f(input logic [7:0] x, input logic [7:0] y,
                                       input logic [0:13] c);
    logic [8:0] r;
    logic [7:0] yy;
    yy = c[8] ? ~y : y;
    r  = 9'd0;
    if (c[12])     r = {1'b0, (c[3] ? (x & y) : (x | y))};
    else if (c[0]) r = {1'b0, x} + {1'b0, yy} + {8'd0, c[7]};
    return r;
  endfunction

  assign {acout2, dout2} = alu_f(op1_2, op2_2, ctrl2);
  assign {acout4, dout4} = alu_f(op1_4, op2_4, ctrl4);

  alu_multibyte_seq #(.NUM_BYTES(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start2), .op(op), .a(a2), .b(b2),
    .alu_en(en2), .alu_op1(op1_2), .alu_op2(op2_2), .alu_ctrl(ctrl2),
    .alu_dout(dout2), .alu_cout(acout2), .busy(busy2), .stall(stall2),
    .done(done2), .result(result2), .cout(cout2), .cmp_gt(gt2),
    .cmp_lt(lt2), .cmp_eq(eq2), .illegal_op(ill2)
  );

  alu_multibyte_seq #(.NUM_BYTES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .op(op), .a(a4), .b(b4),
    .alu_en(en4), .alu_op1(op1_4), .alu_op2(op2_4), .alu_ctrl(ctrl4),
    .alu_dout(dout4), .alu_cout(acout4), .busy(busy4), .stall(stall4),
    .done(done4), .result(result4), .cout(cout4), .cmp_gt(gt4),
    .cmp_lt(lt4), .cmp_eq(eq4), .illegal_op(ill4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Launch one op, scramble inputs after acceptance, wait for done and check it
  task automatic run(input bit w4, input logic [2:0] o, input logic [31:0] aa,
                     input logic [31:0] bb, input bit pulse, input logic [31:0] er,
                     input logic ec, input int ecyc, input logic eill, input string tag);
    int cyc;
    @(negedge clk);
    op = o;
    if (w4) begin a4 = aa; b4 = bb; start4 = 1'b1; end
    else begin a2 = aa[15:0]; b2 = bb[15:0]; start2 = 1'b1; end
    #1 chk({tag, "_stall_acc"}, 32'(w4 ? stall4 : stall2), 32'd1);
    @(negedge clk);
    start2 = 1'b0; start4 = 1'b0;
    op = 3'b110; a2 = ~a2; b2 = ~b2; a4 = ~a4; b4 = ~b4;
    cyc = 1;
    while (!(w4 ? done4 : done2) && cyc < 12) begin
      ci[cyc] = w4 ? ctrl4[7] : ctrl2[7];
      if (pulse && cyc == 1) begin
        if (w4) start4 = 1'b1; else start2 = 1'b1;
      end
      @(negedge clk);
      start2 = 1'b0; start4 = 1'b0;
      cyc++;
    end
    chk({tag, "_latency"}, 32'(cyc), 32'(ecyc));
    chk({tag, "_result"}, w4 ? result4 : 32'(result2), er);
    chk({tag, "_cout"}, 32'(w4 ? cout4 : cout2), 32'(ec));
    chk({tag, "_illegal"}, 32'(w4 ? ill4 : ill2), 32'(eill));
    chk({tag, "_busy_done"}, 32'(w4 ? busy4 : busy2), 32'd1);
    chk({tag, "_stall_done"}, 32'(w4 ? stall4 : stall2), 32'd1);
    chk({tag, "_quiet_done"}, {17'd0, (w4 ? en4 : en2), (w4 ? ctrl4 : ctrl2)}, 32'd0);
    @(negedge clk);
    chk({tag, "_idle_after"}, {30'd0, (w4 ? done4 : done2), (w4 ? busy4 : busy2)}, 32'd0);
  endtask

  initial begin
    start2 = 1'b0; start4 = 1'b0; op = 3'b000;
    a2 = '0; b2 = '0; a4 = '0; b4 = '0;
    for (int i = 0; i < 16; i++) ci[i] = 1'b0;

    // reset state
    #12;
    chk("rst_result", 32'(result2), 32'd0);
    chk("rst_flags", {26'd0, busy2, stall2, done2, cout2, ill2, gt2 | lt2 | eq2}, 32'd0);
    chk("rst_alu", {10'd0, en2, op1_2, op2_2, 1'b0, 4'd0} | 32'(ctrl2), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // ADD with carry from byte 0 into byte 1
    run(0, 3'b000, 32'h00FF, 32'h0001, 0, 32'h0100, 1'b0, 3, 1'b0, "add");
    chk("add_cin_k0", 32'(ci[1]), 32'd0);
    chk("add_cin_k1", 32'(ci[2]), 32'd1);

    run(0, 3'b001, 32'h1234, 32'h1234, 0, 32'h0000, 1'b1, 3, 1'b0, "sub_eq");
    chk("sub_cin_k0", 32'(ci[1]), 32'd1);
    run(0, 3'b001, 32'h0001, 32'h0002, 0, 32'hFFFF, 1'b0, 3, 1'b0, "sub_borrow");

    // preload result with 0xBEEF, then compares must leave result/cout alone
    run(0, 3'b000, 32'hBE00, 32'h00EF, 0, 32'hBEEF, 1'b0, 3, 1'b0, "preload");
    run(0, 3'b010, 32'h0100, 32'h00FF, 0, 32'hBEEF, 1'b0, 3, 1'b0, "cmp_gt");
    chk("cmp_gt_flags", {29'd0, gt2, lt2, eq2}, 32'b100);
    run(0, 3'b010, 32'h0001, 32'h0002, 0, 32'hBEEF, 1'b0, 3, 1'b0, "cmp_lt");
    chk("cmp_lt_flags", {29'd0, gt2, lt2, eq2}, 32'b010);
    run(0, 3'b010, 32'h5A5A, 32'h5A5A, 0, 32'hBEEF, 1'b0, 3, 1'b0, "cmp_eq");
    chk("cmp_eq_flags", {29'd0, gt2, lt2, eq2}, 32'b001);

    run(0, 3'b011, 32'h8001, 32'h0000, 0, 32'h0002, 1'b1, 3, 1'b0, "shl");
    chk("shl_flags_hold", {29'd0, gt2, lt2, eq2}, 32'b001);

    // illegal op: straight to DONE, result and cout untouched
    run(0, 3'b111, 32'h1111, 32'h2222, 0, 32'h0002, 1'b1, 1, 1'b1, "illegal");

    run(0, 3'b100, 32'hF0F0, 32'h0FF0, 0, 32'h00F0, 1'b0, 3, 1'b0, "and");
    // start pulsed during RUN must not be queued
    run(0, 3'b101, 32'hF0F0, 32'h0FF0, 1, 32'hFFF0, 1'b0, 3, 1'b0, "or_pulse");

    // reset asserted during the k=1 cycle
    @(negedge clk);
    op = 3'b000; a2 = 16'h00FF; b2 = 16'h0001; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_result", 32'(result2), 32'd0);
    chk("midrst_outs", {25'd0, busy2, stall2, done2, cout2, eq2, en2, ill2}, 32'd0);
    chk("midrst_ctrl", 32'(ctrl2), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("midrst_no_done", 32'(done2), 32'd0);
    end
    rst_n = 1'b1;

    run(0, 3'b000, 32'h1111, 32'h2222, 0, 32'h3333, 1'b0, 3, 1'b0, "add_after_rst");

    // 4-byte instance: carry ripples through three bytes
    run(1, 3'b000, 32'h00FFFFFF, 32'h00000001, 0, 32'h01000000, 1'b0, 5, 1'b0, "add4");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
